// File: rtl/key_debounce_pkg.sv
// Shared types and 50 MHz default constants for the push-button debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int unsigned DEBOUNCE_20MS = 32'd1000000;
    localparam int unsigned REPEAT_500MS  = 32'd25000000;
    localparam int unsigned REPEAT_100MS  = 32'd5000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Raw key inputs and conditioned key outputs between the buttons and the consumer stage.
interface key_debounce_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    modport master (output KEY, input key_level, key_press, key_release);
    modport slave  (input KEY, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, stability counter, level/pulse outputs.
// Auto-repeat FSM is compiled in when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    logic             acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_c;
    logic             rel_c;
    logic             rep_fire_c;

    assign sync = sync_q[1];

    // Metastability sync; reset to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_n};
    end

    // Accepted raw state flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 1'b1;
            cnt_q <= '0;
        end else if (sync == acc_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_TC) begin
            acc_q <= sync;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Edges between the accepted state and the displayed level.
    assign press_c = ~acc_q & ~level;
    assign rel_c   =  acc_q &  level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            level <= ~acc_q;
            press <= press_c | rep_fire_c;
            rel   <= rel_c;
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] DELAY_TC  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_TC = RPT_W'(REPEAT_PERIOD - 1);

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rcnt_q, rcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Release wins over any pending repeat in the same cycle.
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        rep_fire_c = 1'b0;
        if (rel_c) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_c) begin
                        state_d = DELAY;
                        rcnt_d  = '0;
                    end
                end
                DELAY: begin
                    if (rcnt_q == DELAY_TC) begin
                        rep_fire_c = 1'b1;
                        state_d    = REPEAT;
                        rcnt_d     = '0;
                    end else begin
                        rcnt_d = rcnt_q + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (rcnt_q == PERIOD_TC) begin
                        rep_fire_c = 1'b1;
                        rcnt_d     = '0;
                    end else begin
                        rcnt_d = rcnt_q + RPT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire_c = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// N_KEYS independent debounce channels for the DE1-SoC push-buttons.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat pulses on key_press.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    key_debounce_if.slave bus
);
    logic [N_KEYS-1:0] level_v;
    logic [N_KEYS-1:0] press_v;
    logic [N_KEYS-1:0] rel_v;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key_n (bus.KEY[i]),
            .level (level_v[i]),
            .press (press_v[i]),
            .rel   (rel_v[i])
        );
    end

    assign bus.key_level   = level_v;
    assign bus.key_press   = press_v;
    assign bus.key_release = rel_v;

endmodule

// File: tb/tb_key_debounce.sv
// Directed plus random stimulus for key_debounce, checked against a sample-history model.
module tb_key_debounce;
    localparam int NK = 4;
    localparam int DC = 8;
    localparam int RD = 20;
    localparam int RP = 5;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int EXP_K3_PRESS = 4;
`else
    localparam int EXP_K3_PRESS = 1;
`endif

    logic CLOCK_50;
    logic RESET;
    key_debounce_if #(.N_KEYS(NK)) kif ();

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (kif.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors = 0;
    int miscompares = 0;

    // Model: every KEY sample since reset, plus accepted state and displayed level.
    logic [NK-1:0] hist[$];
    logic [NK-1:0] acc_m;
    logic [NK-1:0] lvl_m;
    int            t_press[NK];

    int press_cnt[NK];
    int rel_cnt[NK];
    int last_press_e[NK];
    int last_rel_e[NK];

    function automatic logic samp(input int idx, input int key);
        logic [NK-1:0] v;
        if (idx < 0) return 1'b1;
        v = hist[idx];
        return v[key];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A level is accepted once DC consecutive synced samples (2 edges old) all differ;
    // the displayed level follows one edge later.
    task automatic model_edge(input logic [NK-1:0] k, output logic [NK-1:0] el,
                              output logic [NK-1:0] ep, output logic [NK-1:0] er);
        int  e;
        int  d;
        logic all_diff;
        hist.push_back(k);
        e = hist.size() - 1;
        for (int i = 0; i < NK; i++) begin
            el[i] = ~acc_m[i];
            ep[i] = el[i] & ~lvl_m[i];
            er[i] = ~el[i] & lvl_m[i];
            if (ep[i]) t_press[i] = e;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            else if (el[i] && lvl_m[i]) begin
                d = e - t_press[i];
                if (d >= RD && ((d - RD) % RP) == 0) ep[i] = 1'b1;
            end
`endif
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++)
                if (samp(e - 2 - j, i) == acc_m[i]) all_diff = 1'b0;
            if (all_diff) acc_m[i] = ~acc_m[i];
        end
        d = 0;
        lvl_m = el;
    endtask

    task automatic step(input logic [NK-1:0] k);
        logic [NK-1:0] el, ep, er;
        int e;
        kif.KEY = k;
        @(posedge CLOCK_50);
        model_edge(k, el, ep, er);
        e = hist.size() - 1;
        #1;
        vectors++;
        assert ({kif.key_level, kif.key_press, kif.key_release} === {el, ep, er}) else begin
            miscompares++;
            $error("FAIL outputs edge %0d: got lvl=%b prs=%b rel=%b, want lvl=%b prs=%b rel=%b",
                   e, kif.key_level, kif.key_press, kif.key_release, el, ep, er);
        end
        chk("press_release_exclusive", int'(|(kif.key_press & kif.key_release)), 0);
        for (int i = 0; i < NK; i++) begin
            if (kif.key_press[i] === 1'b1) begin press_cnt[i]++; last_press_e[i] = e; end
            if (kif.key_release[i] === 1'b1) begin rel_cnt[i]++; last_rel_e[i] = e; end
        end
        @(negedge CLOCK_50);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; last_press_e[i] = -1; last_rel_e[i] = -1;
        end
    endtask

    // Called away from the rising edge; checks the asynchronous clear then holds n edges.
    task automatic do_reset(input int n);
        RESET = 1'b1;
        #1;
        chk("async_rst_level", int'(kif.key_level), 0);
        chk("async_rst_press", int'(kif.key_press), 0);
        chk("async_rst_release", int'(kif.key_release), 0);
        hist.delete();
        acc_m = '1;
        lvl_m = '0;
        for (int i = 0; i < NK; i++) t_press[i] = 0;
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
            chk("rst_hold_outputs", int'({kif.key_level, kif.key_press, kif.key_release}), 0);
        end
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    logic [NK-1:0] cur;
    int            hold[NK];
    int            start;

    initial begin
        RESET   = 1'b1;
        kif.KEY = '1;
        clr_counts();
        do_reset(3);

        // Idle after reset: no activity.
        repeat (50) step(4'b1111);
        chk("idle_press_total", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        chk("idle_release_total", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);

        // Clean press and release on KEY[0].
        clr_counts();
        start = hist.size();
        repeat (14) step(4'b1110);
        chk("k0_press_count", press_cnt[0], 1);
        chk("k0_press_latency", last_press_e[0] - start, 10);
        chk("k0_level_high", int'(kif.key_level[0]), 1);
        start = hist.size();
        repeat (14) step(4'b1111);
        chk("k0_release_count", rel_cnt[0], 1);
        chk("k0_release_latency", last_rel_e[0] - start, 10);
        chk("k0_level_low", int'(kif.key_level[0]), 0);

        // KEY[1] bounces every 3 cycles, then settles low.
        clr_counts();
        start = hist.size();
        for (int c = 0; c < 30; c++) step(((c / 3) % 2 == 1) ? 4'b1111 : 4'b1101);
        repeat (14) step(4'b1101);
        chk("k1_press_count", press_cnt[1], 1);
        chk("k1_press_latency", last_press_e[1] - start, 40);
        repeat (14) step(4'b1111);
        chk("k1_release_count", rel_cnt[1], 1);

        // KEY[2] glitch one cycle shorter than the debounce window.
        clr_counts();
        repeat (7) step(4'b1011);
        repeat (15) step(4'b1111);
        chk("k2_glitch_press", press_cnt[2], 0);
        chk("k2_glitch_release", rel_cnt[2], 0);

        // KEY[3] long hold, released mid repeat period.
        clr_counts();
        start = hist.size();
        repeat (32) step(4'b0111);
        repeat (15) step(4'b1111);
        chk("k3_press_count", press_cnt[3], EXP_K3_PRESS);
        chk("k3_release_count", rel_cnt[3], 1);
        chk("k3_release_latency", last_rel_e[3] - start, 42);

        // Reset while KEY[0] is accepted and held; re-acceptance after full debounce.
        repeat (14) step(4'b1110);
        do_reset(2);
        clr_counts();
        start = hist.size();
        repeat (14) step(4'b1110);
        chk("k0_post_reset_press_count", press_cnt[0], 1);
        chk("k0_post_reset_latency", last_press_e[0] - start, 10);
        repeat (14) step(4'b1111);

        // Random hold lengths on all keys.
        cur = '1;
        for (int i = 0; i < NK; i++) hold[i] = 0;
        repeat (600) begin
            for (int i = 0; i < NK; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = 1'($urandom_range(1, 0));
                    hold[i] = int'($urandom_range(40, 1));
                end else begin
                    hold[i]--;
                end
            end
            step(cur);
        end
        repeat (30) step(4'b1111);
        chk("final_level_released", int'(kif.key_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
